// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and the shared-ALU datapath.
interface mc_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         AdrSrc;
  logic         MemWrite;
  logic         IRWrite;
  logic         RegWrite;
  logic [1:0]   RegSrc;
  logic [1:0]   ImmSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ALUControl;
  logic [1:0]   ResultSrc;
  logic [3:0]   State;

  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, State
  );

  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
           ALUSrcA, ALUSrcB, ALUControl, ResultSrc, State
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: Moore FSM sequencing fetch/decode/execute/write-back,
// NZCV flag register and condition gating of every architectural write.
module mc_controller (
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;

  state_t     state, state_nx;
  logic [3:0] flags;
  logic       cond_ok, cond_nx;

  logic [3:0] cond, rd, cmd;
  logic [1:0] op;
  logic [5:0] funct;
  logic       unused_rn;

  assign cond      = bus.Instr[31:28];
  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign rd        = bus.Instr[15:12];
  assign cmd       = funct[4:1];
  assign unused_rn = ^bus.Instr[19:16];

  // data-processing decode
  logic [1:0] dp_alu;
  logic       no_write, flagw_nz, flagw_cv;

  always_comb begin
    dp_alu   = 2'b00;
    no_write = 1'b0;
    case (cmd)
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin dp_alu = 2'b01; no_write = 1'b1; end
      default: dp_alu = 2'b00;
    endcase
  end

  assign flagw_nz = funct[0];
  assign flagw_cv = funct[0] & (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_nx = 1'b0;
    case (cond)
      4'b0000: cond_nx = z;
      4'b0001: cond_nx = ~z;
      4'b0010: cond_nx = c;
      4'b0011: cond_nx = ~c;
      4'b0100: cond_nx = n;
      4'b0101: cond_nx = ~n;
      4'b0110: cond_nx = v;
      4'b0111: cond_nx = ~v;
      4'b1000: cond_nx = c & ~z;
      4'b1001: cond_nx = ~c | z;
      4'b1010: cond_nx = (n == v);
      4'b1011: cond_nx = (n != v);
      4'b1100: cond_nx = ~z & (n == v);
      4'b1101: cond_nx = z | (n != v);
      4'b1110: cond_nx = 1'b1;
      default: cond_nx = 1'b0;
    endcase
  end

  logic       pc_write, mem_write, ir_write, reg_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, alu_ctl, result_src;

  always_comb begin
    state_nx   = FETCH;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = 2'b00;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        ir_write = 1'b1; pc_write = 1'b1;
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        state_nx = DECODE;
      end
      DECODE: begin
        alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
        case (op)
          2'b01:   state_nx = MEMADR;
          2'b00:   state_nx = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_nx = BRANCH;
          default: state_nx = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = 2'b01;
        state_nx  = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin adr_src = 1'b1; state_nx = MEMWB; end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = cond_ok & (rd != 4'hF);
        pc_write   = cond_ok & (rd == 4'hF);
      end
      MEMWR: begin adr_src = 1'b1; mem_write = cond_ok; end
      EXECUTER: begin alu_ctl = dp_alu; state_nx = ALUWB; end
      EXECUTEI: begin alu_src_b = 2'b01; alu_ctl = dp_alu; state_nx = ALUWB; end
      ALUWB: begin
        reg_write = cond_ok & ~no_write & (rd != 4'hF);
        pc_write  = cond_ok & ~no_write & (rd == 4'hF);
      end
      BRANCH: begin
        alu_src_b = 2'b01; result_src = 2'b10; pc_write = cond_ok;
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= 4'b0000;
      cond_ok <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == DECODE) cond_ok <= cond_nx;
      // an instruction's own flag update lands after its DECODE already sampled cond_ok
      if ((state == EXECUTER || state == EXECUTEI) && cond_ok) begin
        if (flagw_nz) flags[3:2] <= bus.ALUFlags[3:2];
        if (flagw_cv) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // write enables drop in the same cycle reset is seen
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_ctl;
  assign bus.ResultSrc  = result_src;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], op == 2'b10};
  assign bus.State      = state;
endmodule
